axil_apb_port_arbiter: RTL and testbench

- Shares the single AXI4-Lite slave port of the AXI-to-APB bridge among N_MASTERS AXI4-Lite masters.
- Carries one transaction at a time, read or write, end to end: address, then data, then response.
- Arbitration is round-robin across masters. Within a master, reads and writes alternate when both are pending.
- Sits between the CPU/DMA interconnect and the bridge, so the bridge only ever sees one well-ordered requester.

---
 rtl/axil_apb_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_axil_apb_port_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_apb_port_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave port among N_MASTERS masters.
// One transaction (read or write) is carried end to end before the next grant.
module axil_apb_port_arbiter #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  localparam int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic                        s_axi_clk,
  input  logic                        s_axi_aresetn,
  input  logic [N_MASTERS*ADDR_W-1:0] s_awaddr,
  input  logic [N_MASTERS-1:0]        s_awvalid,
  output logic [N_MASTERS-1:0]        s_awready,
  input  logic [N_MASTERS*DATA_W-1:0] s_wdata,
  input  logic [N_MASTERS-1:0]        s_wvalid,
  output logic [N_MASTERS-1:0]        s_wready,
  output logic [1:0]                  s_bresp,
  output logic [N_MASTERS-1:0]        s_bvalid,
  input  logic [N_MASTERS-1:0]        s_bready,
  input  logic [N_MASTERS*ADDR_W-1:0] s_araddr,
  input  logic [N_MASTERS-1:0]        s_arvalid,
  output logic [N_MASTERS-1:0]        s_arready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  output logic [N_MASTERS-1:0]        s_rvalid,
  input  logic [N_MASTERS-1:0]        s_rready,
  output logic [ADDR_W-1:0]           m_awaddr,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [DATA_W-1:0]           m_wdata,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy,
  output logic [2:0]                  state_dbg
);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high; valid never waits on ready.
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [N_MASTERS-1:0]   last_q, last_d;   // 1 = last served type was read
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;

  logic [N_MASTERS-1:0]   req;
  logic                   found_hi, found_lo, win_found, rd_pick;
  logic [IDX_W-1:0]       hi_idx, lo_idx, win_idx;
  logic                   aw_hs, w_hs;

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= IDX_W'(N_MASTERS - 1);
      last_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Granted master's address/data slices are always forwarded.
  always_comb begin
    m_awaddr = '0;
    m_araddr = '0;
    m_wdata  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q == IDX_W'(k)) begin
        m_awaddr = s_awaddr[k*ADDR_W +: ADDR_W];
        m_araddr = s_araddr[k*ADDR_W +: ADDR_W];
        m_wdata  = s_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Winner: first requester above the pointer, else first at or below it.
  always_comb begin
    req      = s_awvalid | s_arvalid;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found_hi && req[k] && (IDX_W'(k) > ptr_q)) begin
        found_hi = 1'b1;
        hi_idx   = IDX_W'(k);
      end
      if (!found_lo && req[k] && (IDX_W'(k) <= ptr_q)) begin
        found_lo = 1'b1;
        lo_idx   = IDX_W'(k);
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? hi_idx : lo_idx;
    rd_pick   = s_arvalid[win_idx] & (~s_awvalid[win_idx] | ~last_q[win_idx]);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bvalid  = '0;
    s_rvalid  = '0;
    s_bresp   = 2'b00;
    s_rresp   = 2'b00;
    s_rdata   = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_arvalid = 1'b0;
    m_bready  = 1'b0;
    m_rready  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d   = win_idx;
          state_d   = rd_pick ? RD_ADDR : WR_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_ADDR: begin
        // A channel already accepted is masked so it cannot transfer twice.
        m_awvalid          = s_awvalid[grant_q] & ~aw_done_q;
        m_wvalid           = s_wvalid[grant_q] & ~w_done_q;
        s_awready[grant_q] = m_awready & ~aw_done_q;
        s_wready[grant_q]  = m_wready & ~w_done_q;
        aw_hs              = m_awvalid & m_awready;
        w_hs               = m_wvalid & m_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid[grant_q] = m_bvalid;
        m_bready          = s_bready[grant_q];
        s_bresp           = m_bresp;
        if (m_bvalid && m_bready) begin
          state_d         = IDLE;
          ptr_d           = grant_q;
          last_d[grant_q] = 1'b0;
        end
      end
      RD_ADDR: begin
        m_arvalid          = s_arvalid[grant_q];
        s_arready[grant_q] = m_arready;
        if (m_arvalid && m_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        s_rvalid[grant_q] = m_rvalid;
        m_rready          = s_rready[grant_q];
        s_rdata           = m_rdata;
        s_rresp           = m_rresp;
        if (m_rvalid && m_rready) begin
          state_d         = IDLE;
          ptr_d           = grant_q;
          last_d[grant_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_axil_apb_port_arbiter.sv
// Randomized scoreboard bench for axil_apb_port_arbiter with a transaction-order
// reference model, a bridge responder and upstream master drivers.
module tb_axil_apb_port_arbiter;
  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int IW     = $clog2(N);
  localparam int D_LSB  = 2;
  localparam int A_LSB  = D_LSB + DW;
  localparam int RD_BIT = A_LSB + AW;
  localparam int M_LSB  = RD_BIT + 1;
  localparam int EXP_W  = M_LSB + 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N*AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [N*DW-1:0] s_wdata = '0;
  logic [N-1:0] s_awvalid = '0, s_wvalid = '0, s_arvalid = '0, s_bready = '0, s_rready = '0;
  logic [N-1:0] s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata;
  logic m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0, m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [1:0] m_bresp = 2'b00, m_rresp = 2'b00;
  logic [DW-1:0] m_rdata = '0;
  logic [IW-1:0] grant_idx;
  logic busy;
  logic [2:0] state_dbg;

  axil_apb_port_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .s_axi_clk(clk), .s_axi_aresetn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_idx(grant_idx), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_dn_q[$];
  logic [EXP_W-1:0] exp_up_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: round-robin pointer and per-master last type (1 = read).
  int mdl_ptr = N - 1;
  logic [N-1:0] mdl_last = '0;

  // Staged per-master transaction contents for the next batch.
  logic [AW-1:0] stg_ar[N], stg_aw[N];
  logic [DW-1:0] stg_wd[N], stg_rd[N];
  logic [1:0] stg_rr[N], stg_br[N];

  // Upstream master driver state.
  logic [N-1:0] pend_rd = '0, pend_wr = '0, ar_acc = '0, aw_acc = '0, w_acc = '0;
  logic [AW-1:0] ar_a[N], aw_a[N];
  logic [DW-1:0] w_d[N];
  int lead = 0;

  // Bridge responder state.
  logic [1:0] wr_tbl[logic [AW-1:0]];
  logic [DW+1:0] rd_tbl[logic [AW-1:0]];
  logic br_aw = 1'b0, br_w = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  int b_dly = 0, r_dly = 0;
  logic [AW-1:0] br_awaddr = '0;
  logic hold_r = 1'b0, w_first = 1'b0;
  int mon_aw_cnt = 0, mon_w_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input int m, input logic rd, input logic [AW-1:0] a,
                                            input logic [DW-1:0] d, input logic [1:0] r);
    return {4'(m), rd, a, d, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_batch(input logic [N-1:0] rd, input logic [N-1:0] wr, input int lead_cyc);
    logic [N-1:0] prd, pwr;
    logic is_rd, hit;
    int k;
    prd = rd;
    pwr = wr;
    for (int j = 0; j < N; j++) begin
      if (rd[j]) rd_tbl[stg_ar[j]] = {stg_rr[j], stg_rd[j]};
      if (wr[j]) wr_tbl[stg_aw[j]] = stg_br[j];
    end
    // Service order: scan from pointer+1; a master holding both alternates type.
    while ((prd | pwr) != '0) begin
      hit = 1'b0;
      for (int i = 1; i <= N; i++) begin
        k = (mdl_ptr + i) % N;
        if (!hit && (prd[k] || pwr[k])) begin
          hit = 1'b1;
          is_rd = prd[k] && (!pwr[k] || !mdl_last[k]);
          if (is_rd) begin
            exp_dn_q.push_back(pack(k, 1'b1, stg_ar[k], stg_rd[k], stg_rr[k]));
            exp_up_q.push_back(pack(k, 1'b1, stg_ar[k], stg_rd[k], stg_rr[k]));
            prd[k] = 1'b0;
          end else begin
            exp_dn_q.push_back(pack(k, 1'b0, stg_aw[k], stg_wd[k], stg_br[k]));
            exp_up_q.push_back(pack(k, 1'b0, stg_aw[k], stg_wd[k], stg_br[k]));
            pwr[k] = 1'b0;
          end
          mdl_last[k] = is_rd;
          mdl_ptr = k;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) begin
      ar_a[j] = stg_ar[j];
      aw_a[j] = stg_aw[j];
      w_d[j]  = stg_wd[j];
    end
    ar_acc = '0;
    aw_acc = '0;
    w_acc = '0;
    lead = lead_cyc;
    pend_rd = rd;
    pend_wr = wr;
  endtask

  task automatic wait_batch(input string name);
    int cyc;
    cyc = 0;
    while ((exp_up_q.size() != 0 || exp_dn_q.size() != 0 || busy) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d_pending required=0_pending", name, exp_up_q.size());
      exp_up_q.delete();
      exp_dn_q.delete();
    end
    repeat (2) @(negedge clk);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic stage_random(input int batch);
    for (int k = 0; k < N; k++) begin
      stg_ar[k] = {16'($urandom()), 8'(batch), 4'(k), 4'h8};
      stg_aw[k] = {16'($urandom()), 8'(batch), 4'(k), 4'h0};
      stg_wd[k] = $urandom();
      stg_rd[k] = $urandom();
      stg_rr[k] = 2'($urandom_range(0, 3));
      stg_br[k] = 2'($urandom_range(0, 3));
    end
  endtask

  // ---------------- upstream masters and bridge responder ----------------
  initial begin : bus
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend_rd = '0; pend_wr = '0; ar_acc = '0; aw_acc = '0; w_acc = '0; lead = 0;
        br_aw = 1'b0; br_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        continue;
      end
      for (int k = 0; k < N; k++) begin
        s_arvalid[k] = pend_rd[k] & ~ar_acc[k] & (lead == 0);
        s_awvalid[k] = pend_wr[k] & ~aw_acc[k] & (lead == 0);
        s_wvalid[k]  = pend_wr[k] & ~w_acc[k];
        s_araddr[k*AW +: AW] = ar_a[k];
        s_awaddr[k*AW +: AW] = aw_a[k];
        s_wdata[k*DW +: DW]  = w_d[k];
        s_bready[k] = ($urandom_range(0, 3) != 0);
        s_rready[k] = ($urandom_range(0, 3) != 0);
      end
      if (lead > 0) lead--;
      m_awready = (w_first && !br_w) ? 1'b0 : 1'($urandom_range(0, 1));
      m_wready  = w_first ? 1'b1 : 1'($urandom_range(0, 1));
      m_arready = 1'($urandom_range(0, 1));
      if (b_pend && b_dly > 0) b_dly--;
      m_bvalid = b_pend && (b_dly == 0);
      m_bresp  = wr_tbl.exists(br_awaddr) ? wr_tbl[br_awaddr] : 2'b00;
      if (r_pend && r_dly > 0 && !hold_r) r_dly--;
      m_rvalid = r_pend && (r_dly == 0) && !hold_r;
      #4;
      if (!rstn) continue;
      for (int k = 0; k < N; k++) begin
        if (s_arvalid[k] && s_arready[k]) ar_acc[k] = 1'b1;
        if (s_awvalid[k] && s_awready[k]) aw_acc[k] = 1'b1;
        if (s_wvalid[k] && s_wready[k]) w_acc[k] = 1'b1;
        if (s_bvalid[k] && s_bready[k]) pend_wr[k] = 1'b0;
        if (s_rvalid[k] && s_rready[k]) pend_rd[k] = 1'b0;
      end
      if (m_bvalid && m_bready) begin b_pend = 1'b0; br_aw = 1'b0; br_w = 1'b0; end
      if (m_awvalid && m_awready) begin br_aw = 1'b1; br_awaddr = m_awaddr; end
      if (m_wvalid && m_wready) br_w = 1'b1;
      if (br_aw && br_w && !b_pend) begin b_pend = 1'b1; b_dly = $urandom_range(0, 3); end
      if (m_rvalid && m_rready) r_pend = 1'b0;
      if (m_arvalid && m_arready) begin
        r_pend = 1'b1;
        r_dly = $urandom_range(0, 3);
        {m_rresp, m_rdata} = rd_tbl.exists(m_araddr) ? rd_tbl[m_araddr] : '0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e;
    logic [N-1:0] oh;
    int m;
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) begin mon_aw_cnt = 0; mon_w_cnt = 0; continue; end
      if (!busy)
        check("idle_quiet", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                             s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, '0);
      if (w_first && mon_w_cnt == 1 && mon_aw_cnt == 0) begin
        check("aw_still_offered", m_awvalid, 1'b1);
        check("w_valid_dropped", m_wvalid, 1'b0);
      end
      // downstream side
      if (m_awvalid && m_awready) begin
        mon_aw_cnt++;
        if (exp_dn_q.size() != 0) begin
          e = exp_dn_q[0];
          check("aw_grant", grant_idx, e[M_LSB +: 4]);
          check("aw_type", e[RD_BIT], 1'b0);
          check("awaddr", m_awaddr, e[A_LSB +: AW]);
        end
      end
      if (m_wvalid && m_wready) begin
        mon_w_cnt++;
        if (exp_dn_q.size() != 0) check("wdata", m_wdata, exp_dn_q[0][D_LSB +: DW]);
      end
      if (m_bvalid && m_bready) begin
        if (exp_dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dn_write_unexpected actual=bresp required=none");
        end else begin
          e = exp_dn_q.pop_front();
          check("dn_write_type", e[RD_BIT], 1'b0);
          check("aw_count", mon_aw_cnt, 1);
          check("w_count", mon_w_cnt, 1);
        end
        mon_aw_cnt = 0;
        mon_w_cnt = 0;
      end
      if (m_arvalid && m_arready) begin
        if (exp_dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dn_read_unexpected actual=ar required=none");
        end else begin
          e = exp_dn_q.pop_front();
          check("ar_type", e[RD_BIT], 1'b1);
          check("ar_grant", grant_idx, e[M_LSB +: 4]);
          check("araddr", m_araddr, e[A_LSB +: AW]);
        end
      end
      // upstream side
      if (s_bvalid != '0 || s_rvalid != '0) begin
        if (exp_up_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL up_unexpected actual=%0h_%0h required=0", s_rvalid, s_bvalid);
        end else begin
          e = exp_up_q[0];
          m = int'(e[M_LSB +: 4]);
          oh = '0;
          oh[m] = 1'b1;
          if (e[RD_BIT]) begin
            check("resp_target", {s_rvalid, s_bvalid}, {oh, {N{1'b0}}});
            check("rdata", s_rdata, e[D_LSB +: DW]);
            check("rresp", s_rresp, e[1:0]);
          end else begin
            check("resp_target", {s_rvalid, s_bvalid}, {{N{1'b0}}, oh});
            check("bresp", s_bresp, e[1:0]);
          end
          if ((s_rvalid & s_rready) != '0 || (s_bvalid & s_bready) != '0)
            void'(exp_up_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [N-1:0] rd, wr;
    int cyc;
    #3;
    check("rst_quiet", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                        s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_idx, '0);
    check("rst_resp", {s_bresp, s_rresp}, 4'h0);
    @(negedge clk); @(negedge clk); #2;
    rstn = 1'b1;

    // single write from master 0
    stage_random(200);
    stg_aw[0] = 32'h10; stg_wd[0] = 32'hA5A5_0001; stg_br[0] = 2'b00;
    start_batch(3'b000, 3'b001, 0);
    wait_batch("single_write");

    // master 1 holds read and write with last type = write: read first
    stage_random(201);
    stg_ar[1] = 32'h30; stg_rd[1] = 32'h3333; stg_rr[1] = 2'b00;
    stg_aw[1] = 32'h34; stg_wd[1] = 32'hBEEF; stg_br[1] = 2'b00;
    start_batch(3'b010, 3'b010, 0);
    wait_batch("alternate");

    // simultaneous reads from masters 0 and 1
    stage_random(202);
    stg_ar[0] = 32'h20; stg_rd[0] = 32'h1111; stg_rr[0] = 2'b00;
    stg_ar[1] = 32'h24; stg_rd[1] = 32'h2222; stg_rr[1] = 2'b00;
    start_batch(3'b011, 3'b000, 0);
    wait_batch("round_robin");

    // W offered three cycles before AW, bridge takes W first
    stage_random(203);
    w_first = 1'b1;
    start_batch(3'b000, 3'b100, 3);
    wait_batch("w_before_aw");
    w_first = 1'b0;

    // bridge timeout error passes through
    stage_random(204);
    stg_ar[0] = 32'h50; stg_rr[0] = 2'b10;
    start_batch(3'b001, 3'b000, 0);
    wait_batch("slverr");

    for (int b = 0; b < 40; b++) begin
      stage_random(b);
      rd = N'($urandom());
      wr = N'($urandom());
      if ((rd | wr) == '0) wr[$urandom_range(0, N-1)] = 1'b1;
      start_batch(rd, wr, $urandom_range(0, 2));
      wait_batch("random");
    end

    // reset while in RD_RESP, pointer previously moved to master 0
    stage_random(205);
    start_batch(3'b001, 3'b000, 0);
    wait_batch("pre_reset");
    hold_r = 1'b1;
    stage_random(206);
    start_batch(3'b100, 3'b000, 0);
    cyc = 0;
    while (!r_pend && cyc < 200) begin @(negedge clk); cyc++; end
    check("reach_rd_resp", r_pend, 1'b1);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check("midrst_quiet", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                           s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_grant", grant_idx, '0);
    exp_dn_q.delete();
    exp_up_q.delete();
    mdl_ptr = N - 1;
    mdl_last = '0;
    hold_r = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    rstn = 1'b1;
    stage_random(207);
    start_batch(3'b011, 3'b000, 0);
    wait_batch("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
